// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex segment codes, blank code and digit index type.
// Segment bit order is {G,F,E,D,C,B,A}, lit = 1.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef logic [1:0] digitIdx_t;

endpackage

// File: rtl/seg_capture_if.sv
// Display-bus bundle: multiplexed digit enables and segment lines in, captured digits out.
interface seg_capture_if;

  logic        DS_EN1;
  logic        DS_EN2;
  logic        DS_EN3;
  logic        DS_EN4;
  logic        DS_A;
  logic        DS_B;
  logic        DS_C;
  logic        DS_D;
  logic        DS_E;
  logic        DS_F;
  logic        DS_G;
  logic [15:0] DIGITS;
  logic [3:0]  DIG_VLD;
  logic        FRAME;
  logic        BAD;
  logic [7:0]  BAD_CNT;

  modport master (
    output DS_EN1, DS_EN2, DS_EN3, DS_EN4,
    output DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G,
    input  DIGITS, DIG_VLD, FRAME, BAD, BAD_CNT
  );

  modport slave (
    input  DS_EN1, DS_EN2, DS_EN3, DS_EN4,
    input  DS_A, DS_B, DS_C, DS_D, DS_E, DS_F, DS_G,
    output DIGITS, DIG_VLD, FRAME, BAD, BAD_CNT
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment to hex decoder; pattern is active-high {G,F,E,D,C,B,A}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid,
  output logic       blank
);

  always_comb begin
    nibble = '0;
    valid  = 1'b1;
    blank  = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Captures the four hex digits shown on a multiplexed seven-segment display bus.
// Optional invalid-pattern counter enabled by defining SEG_CAPTURE_BADCNT_EN.
module seg_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4,
  parameter logic        EN_ACT     = 1'b1,
  parameter logic        SEG_ACT    = 1'b1
) (
  input  logic          CLK,
  input  logic          RST_N,
  seg_capture_if.slave  bus
);

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYC - 1);
  localparam logic [7:0] FULL_CNT = 8'(STABLE_CYC);

  logic [3:0]  enReg, enPrev;
  logic [6:0]  segReg, segPrev;
  logic [7:0]  stableCnt, cntNext;
  logic [3:0]  enAct;
  logic [6:0]  segLit;
  logic        oneHot, changed, sampleNow;
  logic        writeDigit, badHit;
  digitIdx_t   digIdx;
  logic [3:0]  nib;
  logic        codeValid, codeBlank;
  logic [3:0]  vldNext;
  logic [15:0] digits;
  logic [3:0]  digVld;
  logic        frame, bad;

  // Raw levels are registered; the previous copy lets a change restart the dwell.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      enReg   <= {4{~EN_ACT}};
      segReg  <= {7{~SEG_ACT}};
      enPrev  <= {4{~EN_ACT}};
      segPrev <= {7{~SEG_ACT}};
    end else begin
      enReg   <= {bus.DS_EN4, bus.DS_EN3, bus.DS_EN2, bus.DS_EN1};
      segReg  <= {bus.DS_G, bus.DS_F, bus.DS_E, bus.DS_D, bus.DS_C, bus.DS_B, bus.DS_A};
      enPrev  <= enReg;
      segPrev <= segReg;
    end
  end

  always_comb begin
    enAct   = enReg ^ {4{~EN_ACT}};
    segLit  = segReg ^ {7{~SEG_ACT}};
    oneHot  = $onehot(enAct);
    changed = (enReg != enPrev) || (segReg != segPrev);
    digIdx  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (enAct[i]) digIdx = digitIdx_t'(i);
    end
  end

  // Counter saturates at STABLE_CYC so a long dwell samples exactly once.
  always_comb begin
    sampleNow = oneHot && !changed && (stableCnt == LAST_CNT);
    cntNext   = stableCnt;
    if (!oneHot)                    cntNext = '0;
    else if (changed)               cntNext = 8'd1;
    else if (stableCnt != FULL_CNT) cntNext = stableCnt + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) stableCnt <= '0;
    else        stableCnt <= cntNext;
  end

  seg7_decode uDecode (
    .pattern (segLit),
    .nibble  (nib),
    .valid   (codeValid),
    .blank   (codeBlank)
  );

  always_comb begin
    writeDigit = sampleNow && codeValid;
    badHit     = sampleNow && !codeValid && !codeBlank;
    vldNext    = digVld | (4'b0001 << digIdx);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      digits <= '0;
      digVld <= '0;
      frame  <= 1'b0;
      bad    <= 1'b0;
    end else begin
      frame <= 1'b0;
      bad   <= badHit;
      if (writeDigit) begin
        digits[{digIdx, 2'b00} +: 4] <= nib;
        if (vldNext == 4'hF) begin
          digVld <= '0;
          frame  <= 1'b1;
        end else begin
          digVld <= vldNext;
        end
      end
    end
  end

  assign bus.DIGITS  = digits;
  assign bus.DIG_VLD = digVld;
  assign bus.FRAME   = frame;
  assign bus.BAD     = bad;

`ifdef SEG_CAPTURE_BADCNT_EN
  logic [7:0] badCnt;

  always_ff @(posedge CLK) begin
    if (!RST_N)                           badCnt <= '0;
    else if (badHit && badCnt != 8'hFF)   badCnt <= badCnt + 8'd1;
  end

  assign bus.BAD_CNT = badCnt;
`else
  assign bus.BAD_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Directed self-checking bench for seg_capture with default parameters.
module tb_seg_capture;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   frameSeen = 0;
  int   badSeen = 0;
  int   overlapSeen = 0;

  always #5 clk = ~clk;

  seg_capture_if bus ();

  seg_capture #(.STABLE_CYC(4), .EN_ACT(1'b1), .SEG_ACT(1'b1)) dut (
    .CLK   (clk),
    .RST_N (rstN),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.FRAME === 1'b1) frameSeen++;
    if (bus.BAD === 1'b1) badSeen++;
    if (bus.FRAME === 1'b1 && bus.BAD === 1'b1) overlapSeen++;
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] seg);
    {bus.DS_EN4, bus.DS_EN3, bus.DS_EN2, bus.DS_EN1} = en;
    {bus.DS_G, bus.DS_F, bus.DS_E, bus.DS_D, bus.DS_C, bus.DS_B, bus.DS_A} = seg;
  endtask

  task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n);
    drive(en, seg);
    repeat (n) tick();
  endtask

  task automatic doReset();
    drive(4'b0000, 7'h00);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    drive(4'b0101, 7'h7F);
    rstN = 1'b0;
    tick();
    tick();
    checks++; if (bus.DIGITS !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected %h", bus.DIGITS, 16'h0000); end
    checks++; if (bus.DIG_VLD !== 4'b0000) begin errors++; $display("FAIL reset_vld: got %b expected %b", bus.DIG_VLD, 4'b0000); end
    checks++; if (bus.FRAME !== 1'b0 || bus.BAD !== 1'b0) begin errors++; $display("FAIL reset_pulses: got frame=%b bad=%b expected 0 0", bus.FRAME, bus.BAD); end
    checks++; if (bus.BAD_CNT !== 8'd0) begin errors++; $display("FAIL reset_badcnt: got %0d expected 0", bus.BAD_CNT); end
    drive(4'b0000, 7'h00);
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_single_sample();
    int f0, b0;
    doReset();
    f0 = frameSeen;
    b0 = badSeen;
    drive(4'b0001, 7'h06);
    repeat (4) tick();
    checks++; if (bus.DIG_VLD !== 4'b0000) begin errors++; $display("FAIL single_early: got %b expected %b", bus.DIG_VLD, 4'b0000); end
    tick();
    checks++; if (bus.DIG_VLD !== 4'b0001) begin errors++; $display("FAIL single_vld: got %b expected %b", bus.DIG_VLD, 4'b0001); end
    checks++; if (bus.DIGITS !== 16'h0001) begin errors++; $display("FAIL single_digit: got %h expected %h", bus.DIGITS, 16'h0001); end
    repeat (5) tick();
    checks++; if (bus.DIG_VLD !== 4'b0001 || bus.DIGITS !== 16'h0001) begin errors++; $display("FAIL single_hold: got vld=%b digits=%h expected 0001 0001", bus.DIG_VLD, bus.DIGITS); end
    checks++; if (frameSeen != f0 || badSeen != b0) begin errors++; $display("FAIL single_pulses: got frame=%0d bad=%0d expected 0 0", frameSeen - f0, badSeen - b0); end
  endtask

  task automatic test_frame();
    int f0;
    doReset();
    hold(4'b0001, 7'h06, 8);
    hold(4'b0010, 7'h5B, 8);
    hold(4'b0100, 7'h4F, 8);
    f0 = frameSeen;
    drive(4'b1000, 7'h66);
    repeat (4) tick();
    checks++; if (bus.FRAME !== 1'b0 || bus.DIG_VLD !== 4'b0111) begin errors++; $display("FAIL frame_pre: got frame=%b vld=%b expected 0 0111", bus.FRAME, bus.DIG_VLD); end
    tick();
    checks++; if (bus.FRAME !== 1'b1) begin errors++; $display("FAIL frame_pulse: got %b expected 1", bus.FRAME); end
    checks++; if (bus.DIG_VLD !== 4'b0000) begin errors++; $display("FAIL frame_vld: got %b expected %b", bus.DIG_VLD, 4'b0000); end
    checks++; if (bus.DIGITS !== 16'h4321) begin errors++; $display("FAIL frame_digits: got %h expected %h", bus.DIGITS, 16'h4321); end
    repeat (3) tick();
    checks++; if (frameSeen - f0 != 1) begin errors++; $display("FAIL frame_count: got %0d expected 1", frameSeen - f0); end
    checks++; if (bus.DIG_VLD !== 4'b0000 || bus.DIGITS !== 16'h4321) begin errors++; $display("FAIL frame_after: got vld=%b digits=%h expected 0000 4321", bus.DIG_VLD, bus.DIGITS); end
  endtask

  task automatic test_short_dwell();
    int b0;
    b0 = badSeen;
    hold(4'b0010, 7'h6D, 3);
    hold(4'b0000, 7'h00, 4);
    checks++; if (bus.DIGITS !== 16'h4321 || bus.DIG_VLD !== 4'b0000) begin errors++; $display("FAIL short_noupd: got digits=%h vld=%b expected 4321 0000", bus.DIGITS, bus.DIG_VLD); end
    checks++; if (badSeen != b0) begin errors++; $display("FAIL short_nobad: got %0d expected 0", badSeen - b0); end
    hold(4'b0010, 7'h6D, 4);
    drive(4'b0000, 7'h00);
    tick();
    checks++; if (bus.DIGITS !== 16'h4351 || bus.DIG_VLD !== 4'b0010) begin errors++; $display("FAIL short_full: got digits=%h vld=%b expected 4351 0010", bus.DIGITS, bus.DIG_VLD); end
  endtask

  task automatic test_bad();
    int b0;
    b0 = badSeen;
    hold(4'b0100, 7'h7E, 6);
    checks++; if (badSeen - b0 != 1) begin errors++; $display("FAIL bad_pulse: got %0d expected 1", badSeen - b0); end
    checks++; if (bus.DIGITS !== 16'h4351 || bus.DIG_VLD !== 4'b0010) begin errors++; $display("FAIL bad_noupd: got digits=%h vld=%b expected 4351 0010", bus.DIGITS, bus.DIG_VLD); end
`ifdef SEG_CAPTURE_BADCNT_EN
    checks++; if (bus.BAD_CNT !== 8'd1) begin errors++; $display("FAIL bad_cnt1: got %0d expected 1", bus.BAD_CNT); end
`else
    checks++; if (bus.BAD_CNT !== 8'd0) begin errors++; $display("FAIL bad_cnt1: got %0d expected 0", bus.BAD_CNT); end
`endif
    hold(4'b0000, 7'h00, 1);
    repeat (300) begin
      hold(4'b0100, 7'h7E, 5);
      hold(4'b0000, 7'h00, 1);
    end
    checks++; if (badSeen - b0 != 301) begin errors++; $display("FAIL bad_many: got %0d expected 301", badSeen - b0); end
`ifdef SEG_CAPTURE_BADCNT_EN
    checks++; if (bus.BAD_CNT !== 8'd255) begin errors++; $display("FAIL bad_sat: got %0d expected 255", bus.BAD_CNT); end
`else
    checks++; if (bus.BAD_CNT !== 8'd0) begin errors++; $display("FAIL bad_sat: got %0d expected 0", bus.BAD_CNT); end
`endif
  endtask

  task automatic test_no_dwell();
    int b0;
    b0 = badSeen;
    hold(4'b0011, 7'h3F, 8);
    checks++; if (bus.DIGITS !== 16'h4351 || bus.DIG_VLD !== 4'b0010) begin errors++; $display("FAIL multi_en: got digits=%h vld=%b expected 4351 0010", bus.DIGITS, bus.DIG_VLD); end
    hold(4'b0001, 7'h00, 8);
    checks++; if (bus.DIGITS !== 16'h4351 || bus.DIG_VLD !== 4'b0010) begin errors++; $display("FAIL blank: got digits=%h vld=%b expected 4351 0010", bus.DIGITS, bus.DIG_VLD); end
    checks++; if (badSeen != b0) begin errors++; $display("FAIL nodwell_bad: got %0d expected 0", badSeen - b0); end
  endtask

  task automatic test_reset_mid();
    hold(4'b0001, 7'h06, 6);
    checks++; if (bus.DIG_VLD !== 4'b0011) begin errors++; $display("FAIL mid_partial: got %b expected %b", bus.DIG_VLD, 4'b0011); end
    drive(4'b0100, 7'h4F);
    repeat (2) tick();
    rstN = 1'b0;
    tick();
    checks++; if (bus.DIGITS !== 16'h0000 || bus.DIG_VLD !== 4'b0000 || bus.FRAME !== 1'b0 || bus.BAD !== 1'b0 || bus.BAD_CNT !== 8'd0) begin
      errors++; $display("FAIL mid_clear: got digits=%h vld=%b frame=%b bad=%b cnt=%0d expected all 0", bus.DIGITS, bus.DIG_VLD, bus.FRAME, bus.BAD, bus.BAD_CNT);
    end
    rstN = 1'b1;
    repeat (4) tick();
    checks++; if (bus.DIG_VLD !== 4'b0000) begin errors++; $display("FAIL mid_early: got %b expected %b", bus.DIG_VLD, 4'b0000); end
    tick();
    checks++; if (bus.DIG_VLD !== 4'b0100 || bus.DIGITS !== 16'h0300) begin errors++; $display("FAIL mid_resample: got vld=%b digits=%h expected 0100 0300", bus.DIG_VLD, bus.DIGITS); end
  endtask

  task automatic test_decode();
    logic [6:0] codes [16];
    logic [3:0] expNib;
    int b0;
    codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    doReset();
    b0 = badSeen;
    for (int i = 0; i < 16; i++) begin
      expNib = 4'(i);
      hold(4'b1000, codes[i], 4);
      drive(4'b0000, 7'h00);
      tick();
      checks++; if (bus.DIGITS[15:12] !== expNib || bus.DIG_VLD !== 4'b1000) begin
        errors++; $display("FAIL decode_%0d: got nibble=%h vld=%b expected %h 1000", i, bus.DIGITS[15:12], bus.DIG_VLD, expNib);
      end
    end
    checks++; if (badSeen != b0) begin errors++; $display("FAIL decode_nobad: got %0d expected 0", badSeen - b0); end
  endtask

  initial begin
    test_reset();
    test_single_sample();
    test_frame();
    test_short_dwell();
    test_bad();
    test_no_dwell();
    test_reset_mid();
    test_decode();
    checks++; if (overlapSeen != 0) begin errors++; $display("FAIL frame_bad_overlap: got %0d expected 0", overlapSeen); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
